snake_engine: RTL



---
 rtl/snake_if.sv | 39 +++
 rtl/snake_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/snake_if.sv
// Purpose : control/observation bundle between the tick/button logic, the
//           snake_engine and the VGA renderer.
// Signals : start, update, rotL, rotR, grow         - control into the engine
//           head_x, head_y, head_px, body,           - snake geometry out
//           body_valid, length, dir                  - snake geometry out
//           state, inc, game_over                    - game status out
// Modports: master (controller/observer side), slave (engine side).
interface snake_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned COORD_W = 6
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic                         start;
  logic                         update;
  logic                         rotL;
  logic                         rotR;
  logic                         grow;
  logic [COORD_W-1:0]           head_x;
  logic [COORD_W-1:0]           head_y;
  logic [31:0]                  head_px;
  logic [MAX_LEN*2*COORD_W-1:0] body;
  logic [MAX_LEN-1:0]           body_valid;
  logic [LEN_W-1:0]             length;
  logic [1:0]                   dir;
  logic [1:0]                   state;
  logic                         inc;
  logic                         game_over;

  modport master (
    output start, update, rotL, rotR, grow,
    input  head_x, head_y, head_px, body, body_valid, length, dir, state, inc, game_over
  );

  modport slave (
    input  start, update, rotL, rotR, grow,
    output head_x, head_y, head_px, body, body_valid, length, dir, state, inc, game_over
  );
endinterface

// File: rtl/snake_engine.sv
// Purpose : snake game engine. Keeps a head plus up to MAX_LEN body segments
//           on a GRID_W x GRID_H cell grid and advances once per update tick,
//           applying rotation, growth, wall/self collision and level completion.
// Ports   : clk   - system clock
//           reset - synchronous, active-low
//           bus   - snake_if.slave (control in, geometry/status out)
// Config  : define SNAKE_WRAP_EN to wrap the head around the grid edges
//           instead of dying on wall contact.
module snake_engine #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned COORD_W = 6,
  parameter int unsigned GRID_W  = 40,
  parameter int unsigned GRID_H  = 30,
  parameter int unsigned START_X = 9,
  parameter int unsigned START_Y = 4,
  parameter int unsigned CELL_PX = 16
) (
  input logic   clk,
  input logic   reset,
  snake_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned SEG_W = 2 * COORD_W;
  localparam int unsigned SW    = COORD_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  logic [1:0]         r_state,  w_state;
  logic [COORD_W-1:0] r_head_x, w_head_x;
  logic [COORD_W-1:0] r_head_y, w_head_y;
  logic [1:0]         r_dir,    w_dir;
  logic [SEG_W-1:0]   r_body [MAX_LEN];
  logic [SEG_W-1:0]   w_body [MAX_LEN];
  logic [MAX_LEN-1:0] r_valid,  w_valid;
  logic [LEN_W-1:0]   r_len,    w_len;
  logic               r_inc,    w_inc;
  logic               r_game_over, w_game_over;

  logic [1:0]         w_dir_new;
  logic [SW-1:0]      w_nx, w_ny;
  logic [COORD_W-1:0] w_nhx, w_nhy;
  logic               w_wall, w_hit, w_pending;

  // Candidate head: rotate first, then step one cell (widened so -1 is visible)
  always_comb begin
    w_dir_new = r_dir;
    if (bus.rotL && !bus.rotR)      w_dir_new = r_dir + 2'd1;
    else if (bus.rotR && !bus.rotL) w_dir_new = r_dir - 2'd1;

    w_nx = {1'b0, r_head_x};
    w_ny = {1'b0, r_head_y};
    case (w_dir_new)
      2'd0:    w_nx = {1'b0, r_head_x} + SW'(1);
      2'd1:    w_ny = {1'b0, r_head_y} + SW'(1);
      2'd2:    w_nx = {1'b0, r_head_x} + {SW{1'b1}};
      default: w_ny = {1'b0, r_head_y} + {SW{1'b1}};
    endcase

`ifdef SNAKE_WRAP_EN
    w_wall = 1'b0;
    w_nhx  = w_nx[COORD_W-1:0];
    w_nhy  = w_ny[COORD_W-1:0];
    if (w_nx[SW-1])                 w_nhx = COORD_W'(GRID_W - 1);
    else if (w_nx >= SW'(GRID_W))   w_nhx = '0;
    if (w_ny[SW-1])                 w_nhy = COORD_W'(GRID_H - 1);
    else if (w_ny >= SW'(GRID_H))   w_nhy = '0;
`else
    // MSB set means the step went below zero
    w_wall = w_nx[SW-1] | w_ny[SW-1] | (w_nx >= SW'(GRID_W)) | (w_ny >= SW'(GRID_H));
    w_nhx  = w_nx[COORD_W-1:0];
    w_nhy  = w_ny[COORD_W-1:0];
`endif
  end

  // Self-collision; the tail cell is free unless growing since it vacates this tick
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (r_valid[k] && (r_body[k] == {w_nhx, w_nhy}) &&
          !(!bus.grow && (LEN_W'(k + 1) == r_len)))
        w_hit = 1'b1;
    end
  end

  assign w_pending = (r_len == LEN_W'(MAX_LEN));

  // Next-state and next-value logic
  always_comb begin
    w_state  = r_state;
    w_head_x = r_head_x;
    w_head_y = r_head_y;
    w_dir    = r_dir;
    w_valid  = r_valid;
    w_len    = r_len;
    w_inc    = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) w_body[k] = r_body[k];

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state = S_RUN;
      end
      S_RUN: begin
        if (bus.update) begin
          if (w_pending) begin
            // Level restart replaces the move on the tick after completion
            w_head_x = COORD_W'(START_X);
            w_head_y = COORD_W'(START_Y);
            w_dir    = 2'd0;
            w_len    = '0;
            w_valid  = '0;
            for (int k = 0; k < MAX_LEN; k++) w_body[k] = '0;
          end else if (w_wall || w_hit) begin
            w_state = S_DEAD;
          end else begin
            w_head_x = w_nhx;
            w_head_y = w_nhy;
            w_dir    = w_dir_new;
            if (bus.grow) begin
              w_valid = r_valid | (MAX_LEN'(1) << r_len);
              w_len   = r_len + LEN_W'(1);
              if (r_len == LEN_W'(MAX_LEN - 1)) w_inc = 1'b1;
            end
            // Shift the chain; dead slots are kept at zero
            for (int k = 0; k < MAX_LEN; k++) begin
              if (!w_valid[k])  w_body[k] = '0;
              else if (k == 0)  w_body[k] = {r_head_x, r_head_y};
              else              w_body[k] = r_body[k-1];
            end
          end
        end
      end
      S_DEAD: begin
        if (bus.start) begin
          w_state  = S_RUN;
          w_head_x = COORD_W'(START_X);
          w_head_y = COORD_W'(START_Y);
          w_dir    = 2'd0;
          w_len    = '0;
          w_valid  = '0;
          for (int k = 0; k < MAX_LEN; k++) w_body[k] = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_game_over = (w_state == S_DEAD);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_head_x    <= COORD_W'(START_X);
      r_head_y    <= COORD_W'(START_Y);
      r_dir       <= 2'd0;
      r_valid     <= '0;
      r_len       <= '0;
      r_inc       <= 1'b0;
      r_game_over <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) r_body[k] <= '0;
    end else begin
      r_state     <= w_state;
      r_head_x    <= w_head_x;
      r_head_y    <= w_head_y;
      r_dir       <= w_dir;
      r_valid     <= w_valid;
      r_len       <= w_len;
      r_inc       <= w_inc;
      r_game_over <= w_game_over;
      for (int k = 0; k < MAX_LEN; k++) r_body[k] <= w_body[k];
    end
  end

  assign bus.head_x     = r_head_x;
  assign bus.head_y     = r_head_y;
  assign bus.head_px    = {16'(r_head_x) * 16'(CELL_PX), 16'(r_head_y) * 16'(CELL_PX)};
  assign bus.body_valid = r_valid;
  assign bus.length     = r_len;
  assign bus.dir        = r_dir;
  assign bus.state      = r_state;
  assign bus.inc        = r_inc;
  assign bus.game_over  = r_game_over;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_body
    assign bus.body[g*SEG_W +: SEG_W] = r_body[g];
  end
endmodule
